// File: rtl/f_accumulator_pkg.sv
// Shared single-precision float definitions for the multiply/accumulate datapath.
// Holds field widths, bias, canonical special encodings and the sequencer states.
package f_accumulator_pkg;

  localparam int FLOAT_32_EXP_W = 8;
  localparam int FLOAT_32_MAN_W = 23;
  localparam int FLOAT_32_BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/f_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module f_lzc #(
  parameter int W = 28
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  // The highest set bit is visited last, so it decides the count.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/f_accumulator.sv
// Single-precision running-sum accumulator fed by the multiplier product stream.
// Each operand is folded into the total over ALIGN/ADD/NORM/ROUND; in_last presents the sum.
module f_accumulator
  import f_accumulator_pkg::*;
#(
  parameter int EXP_W = FLOAT_32_EXP_W,
  parameter int MAN_W = FLOAT_32_MAN_W,
  parameter int BIAS  = FLOAT_32_BIAS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
  localparam int SW = MAN_W + 5;   // adder result with carry
  localparam int EW = EXP_W + 2;   // signed exponent with headroom
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [EW-1:0] EONE    = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);
  localparam logic [W-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_nx;
  logic [W-1:0] acc, opnd;
  logic         last_q;

  function automatic logic [W-1:0] round_pack(input logic sgn,
                                               input logic signed [EW-1:0] ex,
                                               input logic [MW-1:0] man);
    logic                    up;
    logic [MAN_W+1:0]        m;
    logic signed [EW-1:0]    e;
    up = man[2] & (man[1] | man[0] | man[3]);
    m  = {1'b0, man[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    e  = ex;
    if (m[MAN_W+1]) begin
      m = m >> 1;
      e = e + EONE;
    end
    if (e >= EXP_MAX) round_pack = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else              round_pack = {sgn, e[EXP_W-1:0], m[MAN_W-1:0]};
  endfunction

  // ALIGN: unpack, flush subnormals, order by magnitude, shift the smaller operand
  logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     mag_a, mag_b;
  logic [MW-1:0]    ma, mb, m_big, m_small, m_algn;
  logic             a_nan, b_nan, a_inf, b_inf, swap, sgn_big, sub_c, spc_c;
  logic [W-1:0]     spcv_c;

  always_comb begin
    ea      = acc[W-2:MAN_W];
    fa      = acc[MAN_W-1:0];
    eb      = opnd[W-2:MAN_W];
    fb      = opnd[MAN_W-1:0];
    a_nan   = (&ea) && (|fa);
    b_nan   = (&eb) && (|fb);
    a_inf   = (&ea) && !(|fa);
    b_inf   = (&eb) && !(|fb);
    mag_a   = (ea == '0) ? '0 : acc[W-2:0];
    mag_b   = (eb == '0) ? '0 : opnd[W-2:0];
    ma      = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    mb      = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
    swap    = mag_b > mag_a;
    e_big   = swap ? eb : ea;
    e_small = swap ? ea : eb;
    m_big   = swap ? mb : ma;
    m_small = swap ? ma : mb;
    sgn_big = swap ? opnd[W-1] : acc[W-1];
    sub_c   = acc[W-1] ^ opnd[W-1];
    d       = e_big - e_small;
    if (d >= EXP_W'(MW - 1))
      m_algn = {{(MW-1){1'b0}}, |m_small};
    else
      m_algn = (m_small >> d) |
               {{(MW-1){1'b0}}, |(m_small & ~({MW{1'b1}} << d))};
    spc_c  = 1'b0;
    spcv_c = QNAN_W;
    if (a_nan || b_nan || (a_inf && b_inf && sub_c)) begin
      spc_c = 1'b1;
    end else if (a_inf) begin
      spc_c  = 1'b1;
      spcv_c = acc;
    end else if (b_inf) begin
      spc_c  = 1'b1;
      spcv_c = opnd;
    end
  end

  logic                 sgn_p0, sub_p0, spc_p0;
  logic signed [EW-1:0] exp_p0;
  logic [MW-1:0]        ma_p0, mb_p0;
  logic [W-1:0]         spcv_p0;

  // ADD -> NORM
  logic                 sgn_p1, spc_p1;
  logic signed [EW-1:0] exp_p1;
  logic [SW-1:0]        sum_p1;
  logic [W-1:0]         spcv_p1;

  // NORM: renormalise the raw sum
  logic [CW-1:0]        lz;
  logic                 sgn_n, zero_n;
  logic signed [EW-1:0] exp_n;
  logic [MW-1:0]        man_n;

  f_lzc #(.W(SW)) u_lzc (
    .din (sum_p1),
    .cnt (lz)
  );

  always_comb begin
    sgn_n  = sgn_p1;
    exp_n  = exp_p1;
    man_n  = '0;
    zero_n = 1'b0;
    if (sum_p1[SW-1]) begin
      man_n = {sum_p1[SW-1:2], |sum_p1[1:0]};
      exp_n = exp_p1 + EONE;
    end else if (sum_p1 == '0) begin
      zero_n = 1'b1;
      sgn_n  = 1'b0;
    end else begin
      man_n = MW'(sum_p1 << (lz - CW'(1)));
      exp_n = exp_p1 - $signed(EW'(lz)) + EONE;
      if (exp_n[EW-1] || exp_n == '0) zero_n = 1'b1;
    end
  end

  // NORM -> ROUND
  logic                 sgn_p2, zero_p2, spc_p2;
  logic signed [EW-1:0] exp_p2;
  logic [MW-1:0]        man_p2;
  logic [W-1:0]         spcv_p2;

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      opnd   <= in_data;
      last_q <= in_last;
    end
    sgn_p0  <= sgn_big;
    sub_p0  <= sub_c;
    exp_p0  <= $signed({2'b00, e_big});
    ma_p0   <= m_big;
    mb_p0   <= m_algn;
    spc_p0  <= spc_c;
    spcv_p0 <= spcv_c;
    sgn_p1  <= sgn_p0;
    exp_p1  <= exp_p0;
    sum_p1  <= sub_p0 ? ({1'b0, ma_p0} - {1'b0, mb_p0}) : ({1'b0, ma_p0} + {1'b0, mb_p0});
    spc_p1  <= spc_p0;
    spcv_p1 <= spcv_p0;
    sgn_p2  <= sgn_n;
    exp_p2  <= exp_n;
    man_p2  <= man_n;
    zero_p2 <= zero_n;
    spc_p2  <= spc_p1;
    spcv_p2 <= spcv_p1;
  end

  // ROUND: commit to the accumulator; the handshake in DONE clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (state == ROUND) begin
      acc <= spc_p2  ? spcv_p2 :
             zero_p2 ? {sgn_p2, {(W-1){1'b0}}} :
                       round_pack(sgn_p2, exp_p2, man_p2);
    end else if (state == DONE && out_ready) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : '0;

endmodule

// File: tb/tb_f_accumulator.sv
// Scoreboard bench for f_accumulator: frame sums, specials, backpressure, throughput and reset.
module tb_f_accumulator;
  import f_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, in_valid, in_last, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, out_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_acc = 0;
  int          acc_cyc  = 0;
  logic        ov_prev  = 1'b0;
  logic [31:0] sb_q [$];
  string       tag_q [$];
  logic [31:0] fb [4];

  localparam int NF = 12;
  logic [31:0] tb_beats [NF][4];
  int          tb_n     [NF];
  logic [31:0] tb_exp   [NF];
  string       tb_tag   [NF];

  f_accumulator dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: latency on every rising out_valid, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && !ov_prev) check("latency", 32'(cyc - last_acc), 32'd5);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_empty", 32'(sb_q.size()), 32'd1);
        else check({"out_", tag_q.pop_front()}, out_data, sb_q.pop_front());
      end
    end
    ov_prev <= rstn && out_valid;
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    acc_cyc  = cyc;
    last_acc = cyc;
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] b [4], input int n, input logic [31:0] expv,
                            input string tag, input bit push);
    int prev = 0;
    for (int i = 0; i < n; i++) begin
      if (push && i == n - 1) begin
        sb_q.push_back(expv);
        tag_q.push_back(tag);
      end
      send_beat(b[i], (i == n - 1));
      if (i > 0) check({tag, "_gap"}, 32'(acc_cyc - prev), 32'd5);
      prev = acc_cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding, required 0", sb_q.size());
    $fatal(1);
  end

  initial begin
    tb_beats[0]  = '{32'h3F800000, 32'h40000000, 32'h0, 32'h0}; tb_n[0]  = 2; tb_exp[0]  = 32'h40400000; tb_tag[0]  = "add";
    tb_beats[1]  = '{32'h3FC00000, 32'hBFC00000, 32'h0, 32'h0}; tb_n[1]  = 2; tb_exp[1]  = 32'h00000000; tb_tag[1]  = "cancel";
    tb_beats[2]  = '{32'h3F800000, 32'h33800000, 32'h0, 32'h0}; tb_n[2]  = 2; tb_exp[2]  = 32'h3F800000; tb_tag[2]  = "tie_even";
    tb_beats[3]  = '{32'h3F800000, 32'h33800001, 32'h0, 32'h0}; tb_n[3]  = 2; tb_exp[3]  = 32'h3F800001; tb_tag[3]  = "round_up";
    tb_beats[4]  = '{32'h3FFFFFFF, 32'h33800000, 32'h0, 32'h0}; tb_n[4]  = 2; tb_exp[4]  = 32'h40000000; tb_tag[4]  = "man_ovf";
    tb_beats[5]  = '{32'h40400000, 32'hC0800000, 32'h0, 32'h0}; tb_n[5]  = 2; tb_exp[5]  = 32'hBF800000; tb_tag[5]  = "sub_neg";
    tb_beats[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0}; tb_n[6]  = 2; tb_exp[6]  = POS_INF;      tb_tag[6]  = "overflow";
    tb_beats[7]  = '{32'h7F800000, 32'hFF800000, 32'h0, 32'h0}; tb_n[7]  = 2; tb_exp[7]  = QNAN;         tb_tag[7]  = "inf_cancel";
    tb_beats[8]  = '{32'h7FC00001, 32'h3F800000, 32'h0, 32'h0}; tb_n[8]  = 2; tb_exp[8]  = QNAN;         tb_tag[8]  = "nan_sticky";
    tb_beats[9]  = '{32'h7F800001, 32'h0, 32'h0, 32'h0};        tb_n[9]  = 1; tb_exp[9]  = QNAN;         tb_tag[9]  = "nan_single";
    tb_beats[10] = '{32'h00000001, 32'h0, 32'h0, 32'h0};        tb_n[10] = 1; tb_exp[10] = 32'h00000000; tb_tag[10] = "subnormal";
    tb_beats[11] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    tb_n[11] = 4; tb_exp[11] = 32'h40800000; tb_tag[11] = "four_beats";

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    rstn = 1'b1;

    for (int k = 0; k < NF; k++) begin
      fb = tb_beats[k];
      send_frame(fb, tb_n[k], tb_exp[k], tb_tag[k], 1'b1);
      drain();
    end

    // Hold the result in DONE and confirm it stays put.
    @(posedge clk); #1 out_ready = 1'b0;
    fb = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0};
    send_frame(fb, 2, 32'h40000000, "bp", 1'b1);
    begin
      int w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h40000000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    fb = '{32'h40000000, 32'h0, 32'h0, 32'h0};
    send_frame(fb, 1, 32'h40000000, "after_bp", 1'b1);
    drain();

    // Reset while the second term is in NORM; that frame must vanish.
    fb = '{32'h40A00000, 32'h3F800000, 32'h0, 32'h0};
    send_frame(fb, 2, 32'h0, "rst_frame", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    fb = '{32'h40400000, 32'h0, 32'h0, 32'h0};
    send_frame(fb, 1, 32'h40400000, "after_rst", 1'b1);
    drain();
    repeat (8) @(negedge clk);
    check("no_extra_out", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
